// File: rtl/pattern_field_buffer.sv
// rtl/pattern_field_buffer.sv - PAT field storage with core read/write port and host bulk-load engine
// PATBUF_CLEAR_EN: zero every entry once after reset before the engine goes idle.
module pattern_field_buffer #(
   parameter int D_WIDTH      = 8,
   parameter int BUFP_WIDTH   = 3,
   parameter int FIELDP_WIDTH = 5
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [BUFP_WIDTH+FIELDP_WIDTH-1:0]   buf_fieldp,
   input  logic [BUFP_WIDTH+FIELDP_WIDTH-1:0]   buf_fieldwp,
   input  logic                                 field_write_en,
   input  logic [D_WIDTH-1:0]                   field_in,
   output logic [D_WIDTH-1:0]                   field_out,
   input  logic                                 load_start,
   input  logic [BUFP_WIDTH-1:0]                load_buf,
   input  logic                                 load_valid,
   input  logic [D_WIDTH-1:0]                   load_data,
   output logic                                 load_ready,
   output logic                                 load_busy,
   output logic                                 load_done
);

   localparam int A_WIDTH = BUFP_WIDTH + FIELDP_WIDTH;
   localparam int DEPTH   = 1 << A_WIDTH;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
`ifdef PATBUF_CLEAR_EN
   localparam logic [1:0] S_CLEAR = 2'd2;
`endif

   logic [1:0]              state;
   logic [BUFP_WIDTH-1:0]   lbuf;
   logic [FIELDP_WIDTH-1:0] cnt;
   logic [D_WIDTH-1:0]      mem [DEPTH];
   logic                    load_acc;
   logic [A_WIDTH-1:0]      load_addr;
   logic                    clr_wr;
   logic [A_WIDTH-1:0]      clr_addr;

   // A core write always wins the cycle; the stream simply stalls.
   assign load_ready = (state == S_LOAD) && !field_write_en;
   assign load_busy  = (state != S_IDLE);
   assign load_acc   = load_ready && load_valid && !reset;
   assign load_addr  = {lbuf, cnt};

`ifdef PATBUF_CLEAR_EN
   logic clr_pend;

   // Core data written to the swept address this cycle must not be wiped.
   assign clr_wr = (state == S_CLEAR) && !reset &&
                   !(field_write_en && (buf_fieldwp == clr_addr));
`else
   assign clr_wr   = 1'b0;
   assign clr_addr = '0;
`endif

   always_ff @(posedge clk) begin
      if (clr_wr)
         mem[clr_addr] <= '0;
      if (load_acc)
         mem[load_addr] <= load_data;
      if (field_write_en)
         mem[buf_fieldwp] <= field_in;
   end

   // Write-first: any write landing on the read address is forwarded.
   always_ff @(posedge clk) begin
      if (reset)
         field_out <= '0;
      else if (field_write_en && (buf_fieldwp == buf_fieldp))
         field_out <= field_in;
      else if (load_acc && (load_addr == buf_fieldp))
         field_out <= load_data;
      else if (clr_wr && (clr_addr == buf_fieldp))
         field_out <= '0;
      else
         field_out <= mem[buf_fieldp];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         lbuf      <= '0;
         cnt       <= '0;
         load_done <= 1'b0;
`ifdef PATBUF_CLEAR_EN
         clr_pend  <= 1'b1;
         clr_addr  <= '0;
`endif
      end else begin
         load_done <= 1'b0;
         case (state)
            S_IDLE: begin
`ifdef PATBUF_CLEAR_EN
               if (clr_pend) begin
                  state    <= S_CLEAR;
                  clr_pend <= 1'b0;
                  clr_addr <= '0;
               end else
`endif
               if (load_start) begin
                  state <= S_LOAD;
                  lbuf  <= load_buf;
                  cnt   <= '0;
               end
            end
            S_LOAD: begin
               if (load_acc) begin
                  cnt <= cnt + 1'b1;
                  if (&cnt) begin
                     state     <= S_IDLE;
                     load_done <= 1'b1;
                  end
               end
            end
`ifdef PATBUF_CLEAR_EN
            S_CLEAR: begin
               clr_addr <= clr_addr + 1'b1;
               if (&clr_addr) begin
                  state     <= S_IDLE;
                  load_done <= 1'b1;
               end
            end
`endif
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pattern_field_buffer.sv
// tb/tb_pattern_field_buffer.sv - self-checking bench for pattern_field_buffer
module tb_pattern_field_buffer;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] buf_fieldp, buf_fieldwp, field_in, field_out, load_data;
   logic       field_write_en, load_start, load_valid;
   logic [2:0] load_buf;
   logic       load_ready, load_busy, load_done;

   always #5 clk = ~clk;

   pattern_field_buffer #(.D_WIDTH(8), .BUFP_WIDTH(3), .FIELDP_WIDTH(5)) dut (
      .clk(clk), .reset(reset),
      .buf_fieldp(buf_fieldp), .buf_fieldwp(buf_fieldwp),
      .field_write_en(field_write_en), .field_in(field_in), .field_out(field_out),
      .load_start(load_start), .load_buf(load_buf),
      .load_valid(load_valid), .load_data(load_data),
      .load_ready(load_ready), .load_busy(load_busy), .load_done(load_done)
   );

   typedef struct {
      logic [7:0] val;
      bit         known;
   } exp_t;

   typedef struct {
      logic       we;
      logic [7:0] wa;
      logic [7:0] wd;
      logic [7:0] ra;
      bit         chk;
      logic [7:0] exp;
   } vec_t;

   exp_t       exp_q[$];
   logic [7:0] model [256];
   bit         mknown [256];
   bit         m_load;
   logic [2:0] m_lbuf;
   int         m_cnt;
   int         checks = 0;
   int         errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // One clock: drive inputs, predict, advance, compare.
   task automatic step(input logic rst, input logic we, input logic [7:0] wa, input logic [7:0] wd,
                       input logic [7:0] ra, input logic ls, input logic [2:0] lb,
                       input logic lv, input logic [7:0] ld);
      exp_t       e;
      exp_t       got;
      bit         acc;
      bit         exp_done;
      logic [7:0] la;
      reset = rst; field_write_en = we; buf_fieldwp = wa; field_in = wd;
      buf_fieldp = ra; load_start = ls; load_buf = lb; load_valid = lv; load_data = ld;
      #1;
      chk("load_ready", load_ready, m_load && !we);
      acc = m_load && lv && !we && !rst;
      la  = {m_lbuf, 5'(m_cnt)};
      e.known = 1'b1;
      if (rst)                  e.val = 8'h00;
      else if (we && wa == ra)  e.val = wd;
      else if (acc && la == ra) e.val = ld;
      else begin
         e.val   = model[ra];
         e.known = mknown[ra];
      end
      exp_q.push_back(e);
      if (we) begin model[wa] = wd; mknown[wa] = 1'b1; end
      if (acc) begin model[la] = ld; mknown[la] = 1'b1; end
      exp_done = 1'b0;
      if (rst) begin
         m_load = 1'b0; m_cnt = 0;
      end else if (m_load) begin
         if (acc) begin
            if (m_cnt == 31) begin m_load = 1'b0; m_cnt = 0; exp_done = 1'b1; end
            else m_cnt++;
         end
      end else if (ls) begin
         m_load = 1'b1; m_lbuf = lb; m_cnt = 0;
      end
      @(posedge clk); #1;
      got = exp_q.pop_front();
      if (got.known) chk("field_out", field_out, got.val);
      chk("load_busy", load_busy, m_load);
      chk("load_done", load_done, exp_done);
   endtask

   task automatic idle_read(input logic [7:0] ra);
      step(0, 0, 8'h00, 8'h00, ra, 0, 3'd0, 0, 8'h00);
   endtask

`ifdef PATBUF_CLEAR_EN
   task automatic wait_clear();
      int  busy_cnt = 0;
      bit  seen = 0;
      for (int c = 0; c < 1000 && !seen; c++) begin
         @(posedge clk); #1;
         if (load_busy) busy_cnt++;
         if (load_done) seen = 1;
      end
      chk("clear_done_seen", seen, 1);
      chk("clear_busy_cycles", busy_cnt, 256);
      for (int a = 0; a < 256; a++) begin model[a] = 8'h00; mknown[a] = 1'b1; end
   endtask
`endif

   vec_t tbl [10];

   initial begin
      int  k, cyc;
      bit  done;
      tbl[0] = '{1, 8'h25, 8'hA5, 8'h00, 0, 8'h00};
      tbl[1] = '{0, 8'h00, 8'h00, 8'h25, 1, 8'hA5};
      tbl[2] = '{1, 8'h10, 8'h11, 8'h25, 1, 8'hA5};
      tbl[3] = '{1, 8'h10, 8'h3C, 8'h10, 1, 8'h3C};
      tbl[4] = '{0, 8'h00, 8'h00, 8'h10, 1, 8'h3C};
      tbl[5] = '{1, 8'hFF, 8'h5A, 8'h10, 1, 8'h3C};
      tbl[6] = '{1, 8'h00, 8'hC3, 8'hFF, 1, 8'h5A};
      tbl[7] = '{0, 8'h00, 8'h00, 8'h00, 1, 8'hC3};
      tbl[8] = '{1, 8'h80, 8'h7E, 8'h81, 0, 8'h00};
      tbl[9] = '{0, 8'h00, 8'h00, 8'h80, 1, 8'h7E};

      for (int a = 0; a < 256; a++) begin model[a] = 8'h00; mknown[a] = 1'b0; end
      m_load = 0; m_lbuf = 3'd0; m_cnt = 0;

      reset = 1; field_write_en = 0; buf_fieldwp = 0; field_in = 0; buf_fieldp = 0;
      load_start = 0; load_buf = 0; load_valid = 0; load_data = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_field_out", field_out, 8'h00);
      chk("reset_load_busy", load_busy, 0);
      chk("reset_load_done", load_done, 0);
      chk("reset_load_ready", load_ready, 0);
      reset = 0;
`ifdef PATBUF_CLEAR_EN
      wait_clear();
      idle_read(8'h37);
      chk("clear_read", field_out, 8'h00);
`endif

      for (int i = 0; i < 10; i++) begin
         step(0, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ra, 0, 3'd0, 0, 8'h00);
         if (tbl[i].chk) chk("tbl_field_out", field_out, tbl[i].exp);
      end

      // load_valid in IDLE must be ignored
      step(0, 0, 8'h00, 8'h00, 8'h60, 0, 3'd0, 1, 8'hEE);

      // bulk load buffer 3, reading the address being written; a stray load_start is ignored
      step(0, 0, 8'h00, 8'h00, 8'h00, 1, 3'd3, 0, 8'h00);
      for (int i = 0; i < 32; i++) begin
         step(0, 0, 8'h00, 8'h00, 8'h60 + 8'(i), i == 7, 3'd5, 1, 8'(i));
         chk("bulk_done_timing", load_done, i == 31);
      end
      for (int i = 0; i < 32; i++) begin
         idle_read(8'h60 + 8'(i));
         chk("bulk_read", field_out, 8'(i));
      end

      // collision: two core writes mid-load stall the stream two cycles
      step(0, 0, 8'h00, 8'h00, 8'h00, 1, 3'd2, 0, 8'h00);
      k = 0; cyc = 0; done = 0;
      while (!done && cyc < 60) begin
         logic w;
         cyc++;
         w = (cyc == 5 || cyc == 6);
         step(0, w, (cyc == 5) ? 8'h05 : 8'h06, (cyc == 5) ? 8'hE5 : 8'hE6,
              8'h40 + 8'(k), 0, 3'd0, 1, 8'h40 + 8'(k));
         if (!w) k++;
         if (load_done) done = 1;
      end
      chk("collision_cycles", cyc, 34);
      chk("collision_accepts", k, 32);
      idle_read(8'h05);
      chk("collision_core_wr0", field_out, 8'hE5);
      idle_read(8'h06);
      chk("collision_core_wr1", field_out, 8'hE6);
      for (int i = 0; i < 32; i += 7) begin
         idle_read(8'h40 + 8'(i));
         chk("collision_read", field_out, 8'h40 + 8'(i));
      end

      // reset after 10 accepts into buffer 1
      step(0, 0, 8'h00, 8'h00, 8'h00, 1, 3'd1, 0, 8'h00);
      for (int i = 0; i < 10; i++)
         step(0, 0, 8'h00, 8'h00, 8'h20 + 8'(i), 0, 3'd0, 1, 8'h90 + 8'(i));
      step(1, 0, 8'h00, 8'h00, 8'h00, 0, 3'd0, 0, 8'h00);
      chk("midreset_busy", load_busy, 0);
      chk("midreset_done", load_done, 0);
`ifdef PATBUF_CLEAR_EN
      reset = 0;
      wait_clear();
      idle_read(8'h20);
      chk("midreset_cleared", field_out, 8'h00);
`else
      for (int i = 0; i < 10; i++) begin
         idle_read(8'h20 + 8'(i));
         chk("midreset_kept", field_out, 8'h90 + 8'(i));
      end
      step(0, 0, 8'h00, 8'h00, 8'h00, 1, 3'd1, 0, 8'h00);
      chk("midreset_restart", load_busy, 1);
      step(1, 0, 8'h00, 8'h00, 8'h00, 0, 3'd0, 0, 8'h00);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
